// File: rtl/im2col_spc_dma_launcher.sv
// im2col DMA launcher: drains the descriptor FIFO one entry at a time,
// launches each entry on a single 2D DMA channel, waits for completion and
// signals job completion once the parameter FSM is done and the FIFO is drained.

package im2col_spc_pkg;

  typedef struct packed {
    logic [1:0] q;
  } reg_data_type_t;

  typedef struct packed {
    logic [3:0] q;
  } reg_log_strides_t;

  typedef struct packed {
    reg_data_type_t   data_type;
    reg_log_strides_t log_strides_d1;
  } im2col_spc_reg2hw_t;

  typedef struct packed {
    logic [31:0] input_ptr;
    logic [31:0] output_ptr;
    logic [15:0] size_du_d1;
    logic [15:0] size_du_d2;
    logic [22:0] in_inc_d2;
    logic [7:0]  n_zeros_top;
    logic [7:0]  n_zeros_bottom;
    logic [7:0]  n_zeros_left;
    logic [7:0]  n_zeros_right;
  } dma_if_t;

endpackage

module im2col_spc_dma_launcher
  import im2col_spc_pkg::*;
#(
  parameter int unsigned CNT_WIDTH  = 16,
  parameter logic [31:0] WAIT_LIMIT = 32'hFFFF_FFFF
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  im2col_spc_reg2hw_t   reg2hw_i,
  input  logic                 im2col_start_i,
  input  logic                 im2col_param_done_i,
  input  logic                 fifo_empty_i,
  input  dma_if_t              fifo_data_i,
  output logic                 fifo_pop_o,
  output logic [31:0]          dma_src_ptr_o,
  output logic [31:0]          dma_dst_ptr_o,
  output logic [15:0]          dma_size_d1_o,
  output logic [15:0]          dma_size_d2_o,
  output logic [5:0]           dma_src_inc_d1_o,
  output logic [22:0]          dma_src_inc_d2_o,
  output logic [7:0]           dma_pad_top_o,
  output logic [7:0]           dma_pad_bottom_o,
  output logic [7:0]           dma_pad_left_o,
  output logic [7:0]           dma_pad_right_o,
  output logic [1:0]           dma_data_type_o,
  output logic                 dma_start_valid_o,
  input  logic                 dma_start_ready_i,
  input  logic                 dma_done_i,
  output logic                 busy_o,
  output logic [CNT_WIDTH-1:0] xfer_count_o,
  output logic                 timeout_o,
  output logic                 im2col_done_o
);

  typedef enum logic [2:0] {
    IDLE,
    ARMED,
    LAUNCH,
    WAIT_DONE,
    FINISH
  } state_t;

  state_t               r_state;
  dma_if_t              r_desc;
  logic [1:0]           r_dataType;
  logic [5:0]           r_srcIncD1;
  logic [CNT_WIDTH-1:0] r_xferCount;
  logic [31:0]          r_waitCount;
  logic                 r_timeout;

  logic [5:0]           w_srcIncD1;
  logic                 w_pop;

  // The d1 increment is a power of two in data units, truncated to the 6-bit channel field.
  assign w_srcIncD1 = 6'(32'd1 << reg2hw_i.log_strides_d1.q);

  // A pop is only ever issued from ARMED, so the head is consumed exactly once per launch.
  assign w_pop = (r_state == ARMED) && !fifo_empty_i;

  // Sequencer: latches the head descriptor, holds the launch until accepted,
  // counts completions and watches for a channel that never reports done.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state     <= IDLE;
      r_desc      <= '0;
      r_dataType  <= '0;
      r_srcIncD1  <= '0;
      r_xferCount <= '0;
      r_waitCount <= '0;
      r_timeout   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (im2col_start_i) begin
            r_state     <= ARMED;
            r_xferCount <= '0;
            r_waitCount <= '0;
            r_timeout   <= 1'b0;
          end
        end
        ARMED: begin
          if (!fifo_empty_i) begin
            r_desc     <= fifo_data_i;
            r_dataType <= reg2hw_i.data_type.q;
            r_srcIncD1 <= w_srcIncD1;
            r_state    <= LAUNCH;
          end else if (im2col_param_done_i) begin
            r_state <= FINISH;
          end
        end
        LAUNCH: begin
          if (dma_start_ready_i) begin
            r_state     <= WAIT_DONE;
            r_waitCount <= '0;
          end
        end
        WAIT_DONE: begin
          if (dma_done_i) begin
            r_xferCount <= r_xferCount + 1'b1;
            r_waitCount <= '0;
            r_state     <= ARMED;
          end else begin
            if (r_waitCount != WAIT_LIMIT) begin
              r_waitCount <= r_waitCount + 32'd1;
            end
            if ((WAIT_LIMIT != 32'd0) && ((r_waitCount + 32'd1) == WAIT_LIMIT)) begin
              r_timeout <= 1'b1;
            end
          end
        end
        FINISH: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign fifo_pop_o        = w_pop;
  assign dma_start_valid_o = (r_state == LAUNCH);
  assign busy_o            = (r_state != IDLE);
  assign im2col_done_o     = (r_state == FINISH);
  assign xfer_count_o      = r_xferCount;
  assign timeout_o         = r_timeout;

  assign dma_src_ptr_o    = r_desc.input_ptr;
  assign dma_dst_ptr_o    = r_desc.output_ptr;
  assign dma_size_d1_o    = r_desc.size_du_d1;
  assign dma_size_d2_o    = r_desc.size_du_d2;
  assign dma_src_inc_d1_o = r_srcIncD1;
  assign dma_src_inc_d2_o = r_desc.in_inc_d2;
  assign dma_pad_top_o    = r_desc.n_zeros_top;
  assign dma_pad_bottom_o = r_desc.n_zeros_bottom;
  assign dma_pad_left_o   = r_desc.n_zeros_left;
  assign dma_pad_right_o  = r_desc.n_zeros_right;
  assign dma_data_type_o  = r_dataType;

endmodule

// File: tb/tb_im2col_spc_dma_launcher.sv
// Scoreboard bench for the im2col DMA launcher: a FIFO/channel model feeds
// the DUT, expected launches and job completions are queued as stimulus is
// issued, and an independent monitor compares them when the DUT presents them.

module tb_im2col_spc_dma_launcher;
  import im2col_spc_pkg::*;

  localparam int          CntWidth  = 16;
  localparam logic [31:0] WaitLimit = 32'd10;
  localparam int          JobBudget = 3000;

  typedef struct packed {
    logic [31:0] src;
    logic [31:0] dst;
    logic [15:0] sizeD1;
    logic [15:0] sizeD2;
    logic [5:0]  incD1;
    logic [22:0] incD2;
    logic [7:0]  padTop;
    logic [7:0]  padBottom;
    logic [7:0]  padLeft;
    logic [7:0]  padRight;
    logic [1:0]  dataType;
  } launch_t;

  logic                clk_i               = 1'b0;
  logic                rst_ni              = 1'b1;
  im2col_spc_reg2hw_t  reg2hw_i            = '0;
  logic                im2col_start_i      = 1'b0;
  logic                im2col_param_done_i = 1'b0;
  logic                fifo_empty_i        = 1'b1;
  dma_if_t             fifo_data_i         = '0;
  logic                dma_start_ready_i   = 1'b1;
  logic                modelDone           = 1'b0;
  logic                injectDone          = 1'b0;
  logic                dma_done_i;
  logic                fifo_pop_o;
  logic [31:0]         dma_src_ptr_o;
  logic [31:0]         dma_dst_ptr_o;
  logic [15:0]         dma_size_d1_o;
  logic [15:0]         dma_size_d2_o;
  logic [5:0]          dma_src_inc_d1_o;
  logic [22:0]         dma_src_inc_d2_o;
  logic [7:0]          dma_pad_top_o;
  logic [7:0]          dma_pad_bottom_o;
  logic [7:0]          dma_pad_left_o;
  logic [7:0]          dma_pad_right_o;
  logic [1:0]          dma_data_type_o;
  logic                dma_start_valid_o;
  logic                busy_o;
  logic [CntWidth-1:0] xfer_count_o;
  logic                timeout_o;
  logic                im2col_done_o;

  int testsRun    = 0;
  int testsFailed = 0;

  dma_if_t fifoQ[$];
  launch_t expLaunchQ[$];
  int      expDoneQ[$];

  int popCount      = 0;
  int doneCountdown = 0;
  int doneDelay     = 1;
  int readyMode     = 0;
  int stallLeft     = 0;

  assign dma_done_i = modelDone | injectDone;

  im2col_spc_dma_launcher #(
    .CNT_WIDTH (CntWidth),
    .WAIT_LIMIT(WaitLimit)
  ) dut (
    .clk_i              (clk_i),
    .rst_ni             (rst_ni),
    .reg2hw_i           (reg2hw_i),
    .im2col_start_i     (im2col_start_i),
    .im2col_param_done_i(im2col_param_done_i),
    .fifo_empty_i       (fifo_empty_i),
    .fifo_data_i        (fifo_data_i),
    .fifo_pop_o         (fifo_pop_o),
    .dma_src_ptr_o      (dma_src_ptr_o),
    .dma_dst_ptr_o      (dma_dst_ptr_o),
    .dma_size_d1_o      (dma_size_d1_o),
    .dma_size_d2_o      (dma_size_d2_o),
    .dma_src_inc_d1_o   (dma_src_inc_d1_o),
    .dma_src_inc_d2_o   (dma_src_inc_d2_o),
    .dma_pad_top_o      (dma_pad_top_o),
    .dma_pad_bottom_o   (dma_pad_bottom_o),
    .dma_pad_left_o     (dma_pad_left_o),
    .dma_pad_right_o    (dma_pad_right_o),
    .dma_data_type_o    (dma_data_type_o),
    .dma_start_valid_o  (dma_start_valid_o),
    .dma_start_ready_i  (dma_start_ready_i),
    .dma_done_i         (dma_done_i),
    .busy_o             (busy_o),
    .xfer_count_o       (xfer_count_o),
    .timeout_o          (timeout_o),
    .im2col_done_o      (im2col_done_o)
  );

  // Free-running 100 MHz clock.
  always #5 clk_i = ~clk_i;

  task automatic checkOutput(input string name, input logic [191:0] actual, input logic [191:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  function automatic dma_if_t randomDesc();
    dma_if_t d;
    d.input_ptr      = $urandom;
    d.output_ptr     = $urandom;
    d.size_du_d1     = 16'($urandom);
    d.size_du_d2     = 16'($urandom);
    d.in_inc_d2      = 23'($urandom);
    d.n_zeros_top    = 8'($urandom);
    d.n_zeros_bottom = 8'($urandom);
    d.n_zeros_left   = 8'($urandom);
    d.n_zeros_right  = 8'($urandom);
    return d;
  endfunction

  // Reference mapping: the d1 increment is 2^log_stride data units, kept modulo the 6-bit field.
  function automatic launch_t expectLaunch(input dma_if_t d, input im2col_spc_reg2hw_t r);
    launch_t e;
    longint unsigned step;
    step = 1;
    for (int k = 0; k < int'(r.log_strides_d1.q); k++) step = step * 2;
    e.src       = d.input_ptr;
    e.dst       = d.output_ptr;
    e.sizeD1    = d.size_du_d1;
    e.sizeD2    = d.size_du_d2;
    e.incD1     = 6'(step % 64);
    e.incD2     = d.in_inc_d2;
    e.padTop    = d.n_zeros_top;
    e.padBottom = d.n_zeros_bottom;
    e.padLeft   = d.n_zeros_left;
    e.padRight  = d.n_zeros_right;
    e.dataType  = r.data_type.q;
    return e;
  endfunction

  function automatic launch_t actualLaunch();
    launch_t a;
    a.src       = dma_src_ptr_o;
    a.dst       = dma_dst_ptr_o;
    a.sizeD1    = dma_size_d1_o;
    a.sizeD2    = dma_size_d2_o;
    a.incD1     = dma_src_inc_d1_o;
    a.incD2     = dma_src_inc_d2_o;
    a.padTop    = dma_pad_top_o;
    a.padBottom = dma_pad_bottom_o;
    a.padLeft   = dma_pad_left_o;
    a.padRight  = dma_pad_right_o;
    a.dataType  = dma_data_type_o;
    return a;
  endfunction

  // FIFO and DMA channel model: consumes pops, answers launches with ready
  // according to the current policy and returns done a fixed delay later.
  always @(posedge clk_i) begin : channelModel
    logic popNow;
    logic hsNow;
    popNow = fifo_pop_o;
    hsNow  = dma_start_valid_o & dma_start_ready_i;
    #1;
    if (popNow) begin
      popCount++;
      if (fifoQ.size() > 0) void'(fifoQ.pop_front());
    end
    modelDone = 1'b0;
    if (!rst_ni) begin
      doneCountdown = 0;
    end else if (doneCountdown > 0) begin
      doneCountdown--;
      if (doneCountdown == 0) modelDone = 1'b1;
    end
    if (hsNow && rst_ni) doneCountdown = doneDelay;
    case (readyMode)
      1: dma_start_ready_i = 1'($urandom_range(0, 1));
      2: begin
        if (dma_start_valid_o && stallLeft > 0) begin
          dma_start_ready_i = 1'b0;
          stallLeft--;
        end else begin
          dma_start_ready_i = 1'b1;
        end
      end
      default: dma_start_ready_i = 1'b1;
    endcase
    if (fifoQ.size() > 0) begin
      fifo_empty_i = 1'b0;
      fifo_data_i  = fifoQ[0];
    end else begin
      fifo_empty_i = 1'b1;
      fifo_data_i  = randomDesc();
    end
  end

  // Monitor: every cycle a launch is presented it must match the oldest
  // pending descriptor, and every done pulse must match a queued job.
  always @(negedge clk_i) begin
    if (rst_ni) begin
      if (dma_start_valid_o) begin
        checkOutput("launchPending", expLaunchQ.size() > 0, 1'b1);
        if (expLaunchQ.size() > 0) begin
          checkOutput("launchFields", actualLaunch(), expLaunchQ[0]);
          if (dma_start_ready_i) void'(expLaunchQ.pop_front());
        end
      end
      if (im2col_done_o) begin
        checkOutput("donePending", expDoneQ.size() > 0, 1'b1);
        if (expDoneQ.size() > 0) checkOutput("doneXferCount", xfer_count_o, expDoneQ.pop_front());
      end
    end
  end

  task automatic setupJob(input int delayDone, input int rdyMode);
    reg2hw_i            = im2col_spc_reg2hw_t'($urandom);
    doneDelay           = delayDone;
    readyMode           = rdyMode;
    im2col_param_done_i = 1'b0;
    popCount            = 0;
  endtask

  task automatic pushDesc(input dma_if_t d);
    fifoQ.push_back(d);
    expLaunchQ.push_back(expectLaunch(d, reg2hw_i));
  endtask

  task automatic applyStimulus(input int nDesc);
    expDoneQ.push_back(nDesc);
    im2col_start_i = 1'b1;
    @(negedge clk_i);
    im2col_start_i = 1'b0;
  endtask

  task automatic releaseParam(input int delay);
    repeat (delay) @(negedge clk_i);
    im2col_param_done_i = 1'b1;
  endtask

  task automatic measureValid(output int cnt);
    int guard;
    guard = 0;
    cnt   = 0;
    while (!dma_start_valid_o && guard < 20) begin
      @(negedge clk_i);
      guard++;
    end
    while (dma_start_valid_o && cnt < 50) begin
      cnt++;
      @(negedge clk_i);
    end
  endtask

  task automatic waitJobDone(input int nDesc, input logic expTimeout);
    int cycles;
    cycles = 0;
    while (!im2col_done_o && cycles < JobBudget) begin
      @(negedge clk_i);
      cycles++;
    end
    checkOutput("jobCompleted", cycles < JobBudget, 1'b1);
    checkOutput("jobXferCount", xfer_count_o, nDesc);
    @(negedge clk_i);
    checkOutput("donePulseWidth", im2col_done_o, 1'b0);
    checkOutput("busyAfterJob", busy_o, 1'b0);
    checkOutput("popCount", popCount, nDesc);
    checkOutput("launchesConsumed", expLaunchQ.size(), 0);
    checkOutput("timeoutFlag", timeout_o, expTimeout);
    im2col_param_done_i = 1'b0;
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "Busy"}, busy_o, 1'b0);
    checkOutput({tag, "Valid"}, dma_start_valid_o, 1'b0);
    checkOutput({tag, "Done"}, im2col_done_o, 1'b0);
    checkOutput({tag, "Timeout"}, timeout_o, 1'b0);
    checkOutput({tag, "XferCount"}, xfer_count_o, 0);
    checkOutput({tag, "Pop"}, fifo_pop_o, 1'b0);
    checkOutput({tag, "DmaOutputs"}, actualLaunch(), '0);
  endtask

  // Hard stop in case some wait escapes its own bound.
  initial begin
    #3000000;
    $display("[TB] FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed scenarios followed by randomized jobs.
  initial begin
    dma_if_t d;
    int      cnt;

    #1 rst_ni = 1'b0;
    #1 checkResetState("reset");
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);

    $display("[TB] single descriptor job");
    setupJob(5, 0);
    d                = '0;
    d.input_ptr      = 32'h1000;
    d.output_ptr     = 32'h2000;
    d.size_du_d1     = 16'd3;
    d.size_du_d2     = 16'd3;
    d.n_zeros_left   = 8'd1;
    pushDesc(d);
    applyStimulus(1);
    releaseParam(0);
    measureValid(cnt);
    checkOutput("singleValidCycles", cnt, 1);
    waitJobDone(1, 1'b0);

    $display("[TB] four back-to-back descriptors");
    setupJob(int'($urandom_range(1, 4)), 0);
    for (int i = 0; i < 4; i++) pushDesc(randomDesc());
    im2col_param_done_i = 1'b1;
    applyStimulus(4);
    waitJobDone(4, 1'b0);

    $display("[TB] launch stalled by ready");
    setupJob(3, 2);
    stallLeft = 7;
    pushDesc(randomDesc());
    applyStimulus(1);
    releaseParam(0);
    measureValid(cnt);
    checkOutput("stallValidCycles", cnt, 8);
    checkOutput("stallPopCount", popCount, 1);
    waitJobDone(1, 1'b0);

    $display("[TB] done outside WAIT_DONE");
    setupJob(4, 2);
    stallLeft = 3;
    applyStimulus(1);
    injectDone = 1'b1;
    @(negedge clk_i);
    injectDone = 1'b0;
    @(negedge clk_i);
    checkOutput("armedDoneIgnored", xfer_count_o, 0);
    checkOutput("armedBusy", busy_o, 1'b1);
    pushDesc(randomDesc());
    cnt = 0;
    while (!dma_start_valid_o && cnt < 20) begin
      @(negedge clk_i);
      cnt++;
    end
    injectDone = 1'b1;
    @(negedge clk_i);
    injectDone = 1'b0;
    checkOutput("launchDoneIgnored", xfer_count_o, 0);
    checkOutput("launchStillValid", dma_start_valid_o, 1'b1);
    releaseParam(0);
    waitJobDone(1, 1'b0);

    $display("[TB] wait timeout");
    setupJob(20, 0);
    pushDesc(randomDesc());
    applyStimulus(1);
    releaseParam(0);
    measureValid(cnt);
    checkOutput("timeoutLaunchCycles", cnt, 1);
    repeat (7) @(negedge clk_i);
    checkOutput("timeoutBeforeLimit", timeout_o, 1'b0);
    repeat (4) @(negedge clk_i);
    checkOutput("timeoutAfterLimit", timeout_o, 1'b1);
    waitJobDone(1, 1'b1);

    $display("[TB] reset during WAIT_DONE");
    setupJob(30, 0);
    pushDesc(randomDesc());
    applyStimulus(1);
    checkOutput("timeoutClearedByStart", timeout_o, 1'b0);
    releaseParam(0);
    measureValid(cnt);
    repeat (2) @(negedge clk_i);
    checkOutput("busyBeforeReset", busy_o, 1'b1);
    #2 rst_ni = 1'b0;
    #1 checkResetState("midReset");
    expDoneQ.delete();
    expLaunchQ.delete();
    im2col_param_done_i = 1'b0;
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
    setupJob(2, 0);
    for (int i = 0; i < 3; i++) pushDesc(randomDesc());
    applyStimulus(3);
    releaseParam(1);
    waitJobDone(3, 1'b0);

    $display("[TB] randomized jobs");
    for (int job = 0; job < 12; job++) begin
      int n;
      n = int'($urandom_range(0, 5));
      setupJob(int'($urandom_range(1, 8)), int'($urandom_range(0, 1)));
      for (int i = 0; i < n; i++) pushDesc(randomDesc());
      applyStimulus(n);
      releaseParam(int'($urandom_range(0, 6)));
      waitJobDone(n, 1'b0);
    end

    repeat (3) @(negedge clk_i);
    checkOutput("noPendingDone", expDoneQ.size(), 0);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/im2col_spc_dma_launcher.md
Name: im2col_spc_dma_launcher

Overview:
Consumer stage behind the im2col parameter FSM's descriptor FIFO. It pops one dma_if_t descriptor at a time and drives a single 2D DMA channel with the source, destination, size, stride and padding values. It waits for channel completion, then takes the next descriptor. It raises the im2col done pulse once the parameter FSM reports completion and every queued transfer has finished.

Parameters:
CNT_WIDTH, 16, width of the completed-transfer counter
WAIT_LIMIT, 32'hFFFF_FFFF, cycles allowed in WAIT_DONE before the sticky timeout flag sets; 0 disables the timeout

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
reg2hw_i  in  im2col_spc_reg2hw_t  register file; uses data_type.q and log_strides_d1.q
im2col_start_i  in  1  start pulse from the register file
im2col_param_done_i  in  1  parameter FSM has pushed its last descriptor (level)
fifo_empty_i  in  1  descriptor FIFO empty
fifo_data_i  in  dma_if_t  FIFO head; first-word-fall-through, valid whenever fifo_empty_i=0
fifo_pop_o  out  1  pops the FIFO head
dma_src_ptr_o  out  32  channel source pointer
dma_dst_ptr_o  out  32  channel destination pointer
dma_size_d1_o  out  16  channel d1 size in data units
dma_size_d2_o  out  16  channel d2 size in data units
dma_src_inc_d1_o  out  6  source d1 increment in data units
dma_src_inc_d2_o  out  23  source d2 increment
dma_pad_top_o, dma_pad_bottom_o, dma_pad_left_o, dma_pad_right_o  out  8 each  zero-padding counts
dma_data_type_o  out  2  element type
dma_start_valid_o  out  1  launch request
dma_start_ready_i  in  1  channel accepts the launch
dma_done_i  in  1  one-cycle transfer-complete pulse from the channel
busy_o  out  1  state other than IDLE
xfer_count_o  out  CNT_WIDTH  completed transfers since the last start
timeout_o  out  1  sticky WAIT_DONE timeout flag
im2col_done_o  out  1  one-cycle job-complete pulse

Behaviour:
- Reset values: all outputs 0, state IDLE, descriptor register 0, counters 0.
- States: IDLE, ARMED, LAUNCH, WAIT_DONE, FINISH.
- IDLE
  - im2col_start_i=1 -> ARMED; clear xfer_count, timeout, wait counter.
  - Otherwise stay in IDLE; FIFO contents are ignored.
- ARMED
  - fifo_empty_i=0: assert fifo_pop_o combinationally for exactly one cycle, latch fifo_data_i into the descriptor register on the same edge -> LAUNCH.
  - fifo_empty_i=1 and im2col_param_done_i=1 -> FINISH.
  - Otherwise stay in ARMED.
  - If the FIFO is non-empty and param_done is also high, the FIFO is served first; FINISH is reached only once the FIFO is empty.
- LAUNCH
  - dma_start_valid_o=1; the DMA outputs are driven from the descriptor register.
  - dma_start_ready_i=1 -> WAIT_DONE; valid drops the next cycle.
  - Valid stays high and the outputs stay stable until ready is seen (no retraction).
- WAIT_DONE
  - dma_done_i=1 -> increment xfer_count (wraps at 2^CNT_WIDTH), clear wait counter -> ARMED.
  - The wait counter increments every cycle. When it reaches WAIT_LIMIT (WAIT_LIMIT≠0), timeout_o sets sticky. The state stays in WAIT_DONE, so a late done still completes the transfer.
- FINISH: im2col_done_o=1 for one cycle -> IDLE.
- Minimum ARMED→ARMED loop is 3 cycles (ARMED, LAUNCH with ready=1, WAIT_DONE with done=1).
- dma_done_i outside WAIT_DONE: ignored, no count change.
- im2col_start_i outside IDLE: ignored.
- Output mapping:
  - dma_src_ptr = input_ptr; dma_dst_ptr = output_ptr.
  - dma_size_d1 = size_du_d1; dma_size_d2 = size_du_d2.
  - dma_src_inc_d1 = 6'(1 << log_strides_d1).
  - dma_src_inc_d2 = in_inc_d2.
  - Pads = n_zeros_top / bottom / left / right.
  - dma_data_type = reg2hw_i.data_type.q, sampled when the descriptor is latched.
- DMA outputs hold their last values after a transfer; they are meaningful only while dma_start_valid_o=1.
- Asynchronous reset mid-transfer: return to IDLE at once. The in-flight channel transfer is not aborted by this block.

Test Plan:
- Start, then 1 descriptor (input_ptr=0x1000, output_ptr=0x2000, size_d1=3, size_d2=3, left=1), ready held 1, done 5 cycles after launch, param_done=1 -> one pop; valid high 1 cycle with the matching outputs; xfer_count=1; single im2col_done_o pulse; back to IDLE.
- 4 back-to-back descriptors with FIFO already full, param_done=1 from the start -> 4 pops in order, 4 launches, done pulse only after the 4th dma_done, xfer_count=4.
- Ready held 0 for 7 cycles in LAUNCH, while fifo_data_i changes -> valid stays high 8 cycles, outputs stable, no second pop.
- dma_done_i pulsed in ARMED and LAUNCH -> ignored; xfer_count unchanged.
- WAIT_LIMIT=10, done arrives after 20 cycles -> timeout_o=1 from cycle 10; transfer still counted; the next start clears timeout_o.
- Async reset asserted during WAIT_DONE -> all outputs 0 immediately; a later start resumes normal operation with xfer_count=0.
